edge_scan_controller: RTL and testbench

EDGE_SCAN_CONTROLLER -- requirements
Module: edge_scan_controller

---
 rtl/edge_scan_controller.sv | 166 ++++++++++++++++
 tb/tb_edge_scan_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_scan_controller.sv
// edge_scan_controller: sequences one frame of column feeds into an external
// edge detector, tracks in-flight columns through a LATENCY-deep shift
// register, presents each column's detector flags as they return, and counts
// columns with any flag set (saturating).
// Optional feature: define EDGE_SCAN_IRQ_EN to add a sticky irq output that
// rises with done when the frame found edges, and clears on the next
// accepted start or on reset.
module edge_scan_controller #(
    parameter int COLUMNS = 64,
    parameter int LATENCY = 12,
    parameter int HEIGHT  = 5,
    parameter int CNT_W   = 16
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic                         abort,
    input  logic [17:0]                  threshold,
    input  logic [HEIGHT-1:0]            det_result,
    output logic                         busy,
    output logic                         feed_valid,
    output logic [$clog2(COLUMNS)-1:0]   feed_column,
    output logic [17:0]                  thr_q,
    output logic                         edge_valid,
    output logic [$clog2(COLUMNS)-1:0]   edge_column,
    output logic [HEIGHT-1:0]            edge_mask,
    output logic [CNT_W-1:0]             edge_count,
    output logic                         done
`ifdef EDGE_SCAN_IRQ_EN
    ,
    output logic                         irq
`endif
);

    localparam int COL_W = $clog2(COLUMNS);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLUMNS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;

    // In-flight tracking: valid bit and column index per pipeline slot
    logic [LATENCY-1:0] vld_p;
    logic [COL_W-1:0]   col_p [LATENCY];

    logic start_ok;
    logic abort_ok;
    logic drain_exit;

    // Saturating increment for the edge counter
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Abort wins over start in every state; it only has effect outside IDLE
    assign start_ok   = (state == IDLE) && start && !abort;
    assign abort_ok   = (state != IDLE) && abort;
    assign drain_exit = (state == DRAIN) && (vld_p == '0) && !abort;

    // Results leave the tracking pipe with no extra register stage
    assign edge_valid  = vld_p[LATENCY-1];
    assign edge_column = col_p[LATENCY-1];
    assign edge_mask   = edge_valid ? det_result : '0;

    // Frame sequencer with registered control outputs
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            feed_valid  <= 1'b0;
            feed_column <= '0;
            thr_q       <= '0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort_ok) begin
                state       <= IDLE;
                busy        <= 1'b0;
                feed_valid  <= 1'b0;
                feed_column <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            state       <= FEED;
                            busy        <= 1'b1;
                            feed_valid  <= 1'b1;
                            feed_column <= '0;
                            thr_q       <= threshold;
                        end
                    end
                    FEED: begin
                        if (feed_column == LAST_COL) begin
                            state       <= DRAIN;
                            feed_valid  <= 1'b0;
                            feed_column <= '0;
                        end else begin
                            feed_column <= feed_column + COL_W'(1);
                        end
                    end
                    DRAIN: begin
                        if (drain_exit) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Shift the issued column through a pipe matching the detector depth; flush on abort
    always_ff @(posedge clock) begin
        if (!reset_n || abort_ok) begin
            vld_p <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                col_p[i] <= '0;
            end
        end else begin
            vld_p[0] <= feed_valid;
            col_p[0] <= feed_column;
            for (int i = 1; i < LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                col_p[i] <= col_p[i-1];
            end
        end
    end

    // Count columns with any flag; cleared only by an accepted start or reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            edge_count <= '0;
        end else if (start_ok) begin
            edge_count <= '0;
        end else if (edge_valid && (|edge_mask)) begin
            edge_count <= sat_inc(edge_count);
        end
    end

`ifdef EDGE_SCAN_IRQ_EN
    // Sticky interrupt raised together with done when the frame saw edges
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            irq <= 1'b0;
        end else if (start_ok) begin
            irq <= 1'b0;
        end else if (drain_exit && (edge_count != '0)) begin
            irq <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_edge_scan_controller.sv
// Scoreboard bench for edge_scan_controller (COLUMNS=8, LATENCY=12, CNT_W=2).
// Stimulus pushes expected feed, edge and done records; a negedge monitor pops
// and compares whenever the DUT presents feed_valid, edge_valid or done.
module tb_edge_scan_controller;

    localparam int COLS = 8;
    localparam int LAT  = 12;
    localparam int H    = 5;
    localparam int CW   = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [17:0]   threshold = '0;
    logic [H-1:0]  det_result;
    logic          busy;
    logic          feed_valid;
    logic [2:0]    feed_column;
    logic [17:0]   thr_q;
    logic          edge_valid;
    logic [2:0]    edge_column;
    logic [H-1:0]  edge_mask;
    logic [CW-1:0] edge_count;
    logic          done;
`ifdef EDGE_SCAN_IRQ_EN
    logic          irq;
`endif

    logic [H-1:0] mask_tbl [COLS];
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    logic mon_en = 1'b0;

    typedef struct {
        int cyc;
        int col;
        int val;
    } rec_t;

    rec_t fq[$];
    rec_t eq[$];
    rec_t dq[$];

    edge_scan_controller #(
        .COLUMNS(COLS),
        .LATENCY(LAT),
        .HEIGHT (H),
        .CNT_W  (CW)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .abort      (abort),
        .threshold  (threshold),
        .det_result (det_result),
        .busy       (busy),
        .feed_valid (feed_valid),
        .feed_column(feed_column),
        .thr_q      (thr_q),
        .edge_valid (edge_valid),
        .edge_column(edge_column),
        .edge_mask  (edge_mask),
        .edge_count (edge_count),
        .done       (done)
`ifdef EDGE_SCAN_IRQ_EN
        ,
        .irq        (irq)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Detector stand-in: flags for the returning column, all-ones junk otherwise
    assign det_result = edge_valid ? mask_tbl[edge_column] : '1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: compare whatever the DUT presents against the queued expectations
    always @(negedge clock) begin
        rec_t r;
        if (mon_en) begin
            if (feed_valid) begin
                if (fq.size() == 0) chk("feed_unexpected", 1, 0);
                else begin
                    r = fq.pop_front();
                    chk("feed_cycle", cyc, r.cyc);
                    chk("feed_column", int'(feed_column), r.col);
                end
            end else if (fq.size() > 0 && fq[0].cyc <= cyc) begin
                r = fq.pop_front();
                chk("feed_missing", 0, 1);
            end

            if (edge_valid) begin
                if (eq.size() == 0) chk("edge_unexpected", 1, 0);
                else begin
                    r = eq.pop_front();
                    chk("edge_cycle", cyc, r.cyc);
                    chk("edge_column", int'(edge_column), r.col);
                    chk("edge_mask", int'(edge_mask), r.val);
                end
            end else if (eq.size() > 0 && eq[0].cyc <= cyc) begin
                r = eq.pop_front();
                chk("edge_missing", 0, 1);
            end

            if (done) begin
                if (dq.size() == 0) chk("done_unexpected", 1, 0);
                else begin
                    r = dq.pop_front();
                    chk("done_cycle", cyc, r.cyc);
                    chk("done_count", int'(edge_count), r.val);
                    chk("done_busy", int'(busy), 1);
`ifdef EDGE_SCAN_IRQ_EN
                    chk("done_irq", int'(irq), (r.val != 0) ? 1 : 0);
`endif
                end
            end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
                r = dq.pop_front();
                chk("done_missing", 0, 1);
            end
        end
    end

    // Issue a one-cycle start and queue the whole frame's expected behaviour
    task automatic start_frame(input logic [17:0] thr, input int exp_cnt);
        int s;
        @(posedge clock); #1;
        s = cyc;
        start = 1'b1;
        threshold = thr;
        for (int c = 0; c < COLS; c++) begin
            fq.push_back('{cyc: s + 1 + c, col: c, val: 0});
            eq.push_back('{cyc: s + 1 + LAT + c, col: c, val: int'(mask_tbl[c])});
        end
        dq.push_back('{cyc: s + COLS + LAT + 2, col: 0, val: exp_cnt});
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    // Drop expectations that a flush at the end of cycle 'now' cancels
    task automatic prune(input int now);
        eq.delete();
        dq.delete();
        while (fq.size() > 0 && fq[fq.size()-1].cyc > now) void'(fq.pop_back());
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_feed_valid"}, int'(feed_valid), 0);
        chk({tag, "_feed_column"}, int'(feed_column), 0);
        chk({tag, "_thr_q"}, int'(thr_q), 0);
        chk({tag, "_edge_valid"}, int'(edge_valid), 0);
        chk({tag, "_edge_mask"}, int'(edge_mask), 0);
        chk({tag, "_edge_column"}, int'(edge_column), 0);
        chk({tag, "_edge_count"}, int'(edge_count), 0);
        chk({tag, "_done"}, int'(done), 0);
`ifdef EDGE_SCAN_IRQ_EN
        chk({tag, "_irq"}, int'(irq), 0);
`endif
    endtask

    task automatic set_masks(input logic [H-1:0] m0, m1, m2, m3, m4, m5, m6, m7);
        mask_tbl[0] = m0; mask_tbl[1] = m1; mask_tbl[2] = m2; mask_tbl[3] = m3;
        mask_tbl[4] = m4; mask_tbl[5] = m5; mask_tbl[6] = m6; mask_tbl[7] = m7;
    endtask

    initial begin
        set_masks('0, '0, '0, '0, '0, '0, '0, '0);
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset("init");
        reset_n = 1'b1;
        mon_en = 1'b1;
        repeat (LAT + 2) @(posedge clock);

        // Frame 1: no flags, count stays 0
        start_frame(18'h00123, 0);
        repeat (24) @(posedge clock);
        #1;
        chk("f1_thr_q", int'(thr_q), 'h00123);
        chk("f1_idle_busy", int'(busy), 0);

        // Frame 2: flags on columns 3 and 6
        set_masks('0, '0, '0, 5'b00100, '0, '0, 5'b10001, '0);
        start_frame(18'h00456, 2);
        repeat (26) @(posedge clock);
        #1;
        chk("f2_count_hold", int'(edge_count), 2);

        // Frame 3: threshold changed and start re-pulsed mid-frame
        start_frame(18'h2AAAA, 2);
        repeat (2) @(posedge clock);
        #1;
        threshold = 18'h15555;
        @(posedge clock); #1;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        chk("f3_thr_hold_busy", int'(thr_q), 'h2AAAA);
        repeat (24) @(posedge clock);
        #1;
        chk("f3_thr_hold_idle", int'(thr_q), 'h2AAAA);

        // Frame 4: every column flagged, two-bit counter saturates at 3
        set_masks(5'b00001, 5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00011, 5'b00101, 5'b11111);
        start_frame(18'h00777, 3);
        repeat (26) @(posedge clock);
        #1;
        chk("f4_count_sat", int'(edge_count), 3);

        // Frame 5: abort at cycle 5 of the frame
        start_frame(18'h00001, 0);
        repeat (4) @(posedge clock);
        #1;
        abort = 1'b1;
        prune(cyc);
        @(posedge clock); #1;
        abort = 1'b0;
        chk("f5_abort_busy", int'(busy), 0);
        chk("f5_abort_feed", int'(feed_valid), 0);
        chk("f5_abort_count", int'(edge_count), 0);
        repeat (30) @(posedge clock);
        #1;
        chk("f5_thr_q", int'(thr_q), 1);

        // Frame 6: reset pulled at cycle 10 of the frame
        start_frame(18'h3FFFF, 0);
        repeat (9) @(posedge clock);
        #1;
        reset_n = 1'b0;
        prune(cyc);
        @(posedge clock); #1;
        check_reset("midreset");
        reset_n = 1'b1;
        repeat (LAT + 3) @(posedge clock);

        // Frame 7: full frame after reset, single flagged column
        set_masks(5'b01000, '0, '0, '0, '0, '0, '0, '0);
        start_frame(18'h0ABCD, 1);
        repeat (30) @(posedge clock);
        #1;
        chk("f7_count_hold", int'(edge_count), 1);
        chk("f7_thr_q", int'(thr_q), 'h0ABCD);
        chk("f7_idle_busy", int'(busy), 0);
        chk("queues_drained", fq.size() + eq.size() + dq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
